// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared types and helpers for the lane-parallel 2-D convolver:
//               FSM state encoding, derived-size functions and the
//               ReLU/saturation selector used by every MAC lane.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_MAC     = 3'd2,
        ST_WRITE   = 3'd3,
        ST_FINISH  = 3'd4
    } conv_state_t;

    // How a post-shift sum maps onto the narrow output word
    typedef enum logic [1:0] {
        SAT_PASS = 2'd0,
        SAT_MAX  = 2'd1,
        SAT_MIN  = 2'd2,
        SAT_ZERO = 2'd3
    } sat_sel_t;

    // Side length of the valid (no padding) output map
    function automatic int calc_out(input int size, input int size_ker);
        return size - size_ker + 1;
    endfunction

    // Accumulator width wide enough that a full kernel sum never overflows
    function automatic int calc_acc_w(input int width_bit, input int size_ker);
        return 2 * width_bit + $clog2(size_ker * size_ker);
    endfunction

    // ReLU has priority over saturation: a clamped negative is 0, not MIN
    function automatic sat_sel_t sat_select(input logic signed [63:0] val,
                                            input logic              relu,
                                            input int                width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (relu && (val < 0))
            return SAT_ZERO;
        else if (val > hi)
            return SAT_MAX;
        else if (val < lo)
            return SAT_MIN;
        else
            return SAT_PASS;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_mac_lane.sv
`default_nettype none
// ============================================================================
// Module      : conv_mac_lane
// Description : One convolution lane: signed tap multiply, full-precision
//               accumulate, then arithmetic shift, ReLU and saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_mac_lane
    import conv_pkg::*;
#(
    parameter int WIDTH_BIT = 8,
    parameter int ACC_W     = 20
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        i_clear,
    input  logic                        i_en,
    input  logic signed [WIDTH_BIT-1:0] i_pix,
    input  logic signed [WIDTH_BIT-1:0] i_coef,
    input  logic        [3:0]           i_shift,
    input  logic                        i_relu_en,
    output logic signed [WIDTH_BIT-1:0] o_result
);

    logic signed [2*WIDTH_BIT-1:0] w_prod;
    logic signed [ACC_W-1:0]       r_acc;
    logic signed [ACC_W-1:0]       w_shifted;
    sat_sel_t                      w_sel;

    assign w_prod    = (2*WIDTH_BIT)'(i_pix) * (2*WIDTH_BIT)'(i_coef);
    assign w_shifted = r_acc >>> i_shift;
    assign w_sel     = sat_select(64'(w_shifted), i_relu_en, WIDTH_BIT);

    // Accumulator: cleared ahead of each MAC phase, one tap per enabled cycle
    always_ff @(posedge clock) begin
        if (reset || i_clear)
            r_acc <= '0;
        else if (i_en)
            r_acc <= r_acc + ACC_W'(w_prod);
    end

    // Post-process the held sum into the output word
    always_comb begin
        o_result = w_shifted[WIDTH_BIT-1:0];
        case (w_sel)
            SAT_MAX:  o_result = {1'b0, {(WIDTH_BIT-1){1'b1}}};
            SAT_MIN:  o_result = {1'b1, {(WIDTH_BIT-1){1'b0}}};
            SAT_ZERO: o_result = '0;
            default:  o_result = w_shifted[WIDTH_BIT-1:0];
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/conv2d_lanes.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_lanes
// Description : Valid-mode 2-D convolution computed LANES output rows at a
//               time. One control FSM and shared tap/position counters drive
//               LANES identical MAC lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module conv2d_lanes
    import conv_pkg::*;
#(
    parameter  int SIZE      = 8,
    parameter  int SIZEKer   = 3,
    parameter  int WIDTH_BIT = 8,
    parameter  int LANES     = 4,
    localparam int OUT       = conv_pkg::calc_out(SIZE, SIZEKer)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic signed [WIDTH_BIT-1:0] inpMatrixI [SIZE][SIZE],
    input  logic signed [WIDTH_BIT-1:0] kernel [SIZEKer][SIZEKer],
    input  logic        [3:0]           shift,
    input  logic                        relu_en,
    output logic                        busy,
    output logic                        done,
    output logic signed [WIDTH_BIT-1:0] convIxKernelOut [OUT][OUT]
);

    localparam int G     = (OUT + LANES - 1) / LANES;
    localparam int ACC_W = calc_acc_w(WIDTH_BIT, SIZEKer);
    localparam int IDX_W = (SIZE > 1)    ? $clog2(SIZE)    : 1;
    localparam int KW    = (SIZEKer > 1) ? $clog2(SIZEKer) : 1;
    localparam int OW    = (OUT > 1)     ? $clog2(OUT)     : 1;
    localparam int GW    = (G > 1)       ? $clog2(G)       : 1;

    conv_state_t                  r_state;
    conv_state_t                  w_next;
    logic signed [WIDTH_BIT-1:0]  r_img [SIZE][SIZE];
    logic signed [WIDTH_BIT-1:0]  r_ker [SIZEKer][SIZEKer];
    logic        [3:0]            r_shift;
    logic                         r_relu;
    logic        [KW-1:0]         r_kr;
    logic        [KW-1:0]         r_kc;
    logic        [OW-1:0]         r_col;
    logic        [GW-1:0]         r_grp;
    logic signed [WIDTH_BIT-1:0]  r_out [OUT][OUT];

    logic                         w_last_tap;
    logic                         w_last_pos;
    logic                         w_clear;
    logic                         w_en;
    logic        [LANES-1:0]      w_active;
    logic        [OW-1:0]         w_orow [LANES];
    logic signed [WIDTH_BIT-1:0]  w_res  [LANES];

    assign w_last_tap = (r_kr == KW'(SIZEKer - 1)) && (r_kc == KW'(SIZEKer - 1));
    assign w_last_pos = (r_col == OW'(OUT - 1)) && (r_grp == GW'(G - 1));
    assign w_clear    = (r_state == ST_CAPTURE) || (r_state == ST_WRITE);
    assign w_en       = (r_state == ST_MAC);
    assign convIxKernelOut = r_out;

    // State register
    always_ff @(posedge clock) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state and status decode
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_IDLE:    if (start) w_next = ST_CAPTURE;
            ST_CAPTURE: begin
                busy   = 1'b1;
                w_next = ST_MAC;
            end
            ST_MAC: begin
                busy = 1'b1;
                if (w_last_tap) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                busy   = 1'b1;
                w_next = w_last_pos ? ST_FINISH : ST_MAC;
            end
            ST_FINISH: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default:    w_next = ST_IDLE;
        endcase
    end

    // Operand capture, shared tap/position counters and result map writes
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift <= '0;
            r_relu  <= 1'b0;
            r_kr    <= '0;
            r_kc    <= '0;
            r_col   <= '0;
            r_grp   <= '0;
            for (int i = 0; i < SIZE; i++)
                for (int j = 0; j < SIZE; j++)
                    r_img[i][j] <= '0;
            for (int i = 0; i < SIZEKer; i++)
                for (int j = 0; j < SIZEKer; j++)
                    r_ker[i][j] <= '0;
            for (int i = 0; i < OUT; i++)
                for (int j = 0; j < OUT; j++)
                    r_out[i][j] <= '0;
        end else begin
            case (r_state)
                ST_CAPTURE: begin
                    r_img   <= inpMatrixI;
                    r_ker   <= kernel;
                    r_shift <= shift;
                    r_relu  <= relu_en;
                    r_kr    <= '0;
                    r_kc    <= '0;
                    r_col   <= '0;
                    r_grp   <= '0;
                    for (int i = 0; i < OUT; i++)
                        for (int j = 0; j < OUT; j++)
                            r_out[i][j] <= '0;
                end
                ST_MAC: begin
                    if (r_kc == KW'(SIZEKer - 1)) begin
                        r_kc <= '0;
                        r_kr <= (r_kr == KW'(SIZEKer - 1)) ? '0 : r_kr + 1'b1;
                    end else begin
                        r_kc <= r_kc + 1'b1;
                    end
                end
                ST_WRITE: begin
                    for (int p = 0; p < LANES; p++)
                        if (w_active[p])
                            r_out[w_orow[p]][r_col] <= w_res[p];
                    if (r_col == OW'(OUT - 1)) begin
                        r_col <= '0;
                        r_grp <= r_grp + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Lane p of group g owns output row g*LANES+p; rows past OUT stay idle
    for (genvar p = 0; p < LANES; p++) begin : g_lane
        logic [IDX_W-1:0] w_prow;
        logic [IDX_W-1:0] w_pcol;

        assign w_active[p] = (int'(r_grp) * LANES + p) < OUT;
        assign w_orow[p]   = OW'(int'(r_grp) * LANES + p);
        // Idle lanes read pixel row 0 so the index never leaves the image
        assign w_prow = w_active[p] ? IDX_W'(int'(r_grp) * LANES + p + int'(r_kr)) : '0;
        assign w_pcol = IDX_W'(int'(r_col) + int'(r_kc));

        conv_mac_lane #(
            .WIDTH_BIT (WIDTH_BIT),
            .ACC_W     (ACC_W)
        ) u_lane (
            .clock     (clock),
            .reset     (reset),
            .i_clear   (w_clear),
            .i_en      (w_en),
            .i_pix     (r_img[w_prow][w_pcol]),
            .i_coef    (r_ker[r_kr][r_kc]),
            .i_shift   (r_shift),
            .i_relu_en (r_relu),
            .o_result  (w_res[p])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_conv2d_lanes.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv2d_lanes
// Description : Directed, table-driven self-checking bench for conv2d_lanes
//               (8x8 image, 3x3 kernel, 8-bit words, 4 lanes).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2d_lanes;

    localparam int SIZE    = 8;
    localparam int SIZEKER = 3;
    localparam int WB      = 8;
    localparam int LANES   = 4;
    localparam int OUT     = 6;
    localparam int LAT     = 122;
    localparam int BOUND   = 300;

    logic clock = 1'b0;
    logic reset;
    logic start;
    logic relu_en;
    logic busy;
    logic done;
    logic [3:0] shift;
    logic signed [WB-1:0] img [SIZE][SIZE];
    logic signed [WB-1:0] ker [SIZEKER][SIZEKER];
    logic signed [WB-1:0] res [OUT][OUT];

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int pix;
        int kv;
        int sh;
        int relu;
        int exp;
    } vec_t;

    always #5 clock = ~clock;

    conv2d_lanes #(
        .SIZE      (SIZE),
        .SIZEKer   (SIZEKER),
        .WIDTH_BIT (WB),
        .LANES     (LANES)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .inpMatrixI      (img),
        .kernel          (ker),
        .shift           (shift),
        .relu_en         (relu_en),
        .busy            (busy),
        .done            (done),
        .convIxKernelOut (res)
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic set_uniform(input int p, input int k);
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
                img[i][j] = WB'(p);
        for (int i = 0; i < SIZEKER; i++)
            for (int j = 0; j < SIZEKER; j++)
                ker[i][j] = WB'(k);
    endtask

    // Irregular image and asymmetric kernel: exposes row/column/tap mix-ups
    task automatic set_pattern();
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
                img[i][j] = WB'(((i * 8 + j) * 7) % 41 - 20);
        for (int i = 0; i < SIZEKER; i++)
            for (int j = 0; j < SIZEKER; j++)
                ker[i][j] = WB'((i * 3 + j - 4) * 5);
    endtask

    function automatic int model(input int r, input int c, input int sh, input int relu);
        int s;
        s = 0;
        for (int k = 0; k < SIZEKER; k++)
            for (int l = 0; l < SIZEKER; l++)
                s += int'(img[r+k][c+l]) * int'(ker[k][l]);
        s = s >>> sh;
        if (relu != 0 && s < 0) s = 0;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    function automatic int count_uniform(input int exp);
        int errs;
        errs = 0;
        for (int i = 0; i < OUT; i++)
            for (int j = 0; j < OUT; j++)
                if (int'(res[i][j]) != exp) errs++;
        return errs;
    endfunction

    // Returns with the bench sitting in cycle 1 (the CAPTURE cycle)
    task automatic launch();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // Launch, time the run, then check busy/done framing around completion
    task automatic run_and_check(input string name);
        int  cyc;
        bit  busy_ok;
        launch();
        cyc     = 1;
        busy_ok = 1'b1;
        while (!done && cyc < BOUND) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clock);
            #1 cyc++;
        end
        check({name, " latency"}, cyc, LAT);
        check({name, " busy during run"}, int'(busy_ok), 1);
        check({name, " busy low at done"}, int'(busy), 0);
        @(posedge clock);
        #1 check({name, " done one cycle"}, int'(done), 0);
    endtask

    initial begin
        vec_t vecs[8];
        int   errs;
        int   cyc;
        bit   seen;

        vecs[0] = '{pix: 1,   kv: 1,    sh: 0, relu: 0, exp: 9};
        vecs[1] = '{pix: 127, kv: 127,  sh: 0, relu: 0, exp: 127};
        vecs[2] = '{pix: 127, kv: -127, sh: 0, relu: 0, exp: -128};
        vecs[3] = '{pix: 127, kv: -127, sh: 0, relu: 1, exp: 0};
        vecs[4] = '{pix: 1,   kv: 2,    sh: 1, relu: 0, exp: 9};
        vecs[5] = '{pix: 1,   kv: 2,    sh: 4, relu: 0, exp: 1};
        vecs[6] = '{pix: -1,  kv: 1,    sh: 2, relu: 0, exp: -3};
        vecs[7] = '{pix: 3,   kv: -2,   sh: 0, relu: 0, exp: -54};

        reset   = 1'b1;
        start   = 1'b0;
        shift   = 4'd0;
        relu_en = 1'b0;
        set_uniform(0, 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset outputs nonzero", count_uniform(0), 0);

        // Uniform image/kernel table
        for (int v = 0; v < 8; v++) begin
            set_uniform(vecs[v].pix, vecs[v].kv);
            shift   = 4'(vecs[v].sh);
            relu_en = vecs[v].relu[0];
            run_and_check($sformatf("vec%0d", v));
            check($sformatf("vec%0d wrong outputs", v), count_uniform(vecs[v].exp), 0);
        end

        // Row-index image through identity-centre kernel: out[r][c] = r+1
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
                img[i][j] = WB'(i);
        for (int i = 0; i < SIZEKER; i++)
            for (int j = 0; j < SIZEKER; j++)
                ker[i][j] = (i == 1 && j == 1) ? 8'sd1 : 8'sd0;
        shift   = 4'd0;
        relu_en = 1'b0;
        run_and_check("rowidx");
        errs = 0;
        for (int r = 0; r < OUT; r++)
            for (int c = 0; c < OUT; c++)
                if (int'(res[r][c]) != r + 1) errs++;
        check("rowidx wrong outputs", errs, 0);
        check("rowidx out[4][0]", int'(res[4][0]), 5);
        check("rowidx out[5][5]", int'(res[5][5]), 6);

        // Irregular data against a reference convolution
        for (int t = 0; t < 2; t++) begin
            set_pattern();
            shift   = (t == 0) ? 4'd3 : 4'd0;
            relu_en = (t == 1);
            run_and_check($sformatf("pattern%0d", t));
            errs = 0;
            for (int r = 0; r < OUT; r++)
                for (int c = 0; c < OUT; c++)
                    if (int'(res[r][c]) != model(r, c, int'(shift), int'(relu_en))) errs++;
            check($sformatf("pattern%0d wrong outputs", t), errs, 0);
        end

        // Reset at cycle 50 aborts the run and clears partial results
        set_uniform(1, 1);
        shift   = 4'd0;
        relu_en = 1'b0;
        launch();
        repeat (49) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        check("abort busy", int'(busy), 0);
        check("abort outputs nonzero", count_uniform(0), 0);
        seen = 1'b0;
        repeat (150) begin
            @(posedge clock);
            #1 if (done || busy) seen = 1'b1;
        end
        check("abort stray activity", int'(seen), 0);
        run_and_check("restart");
        check("restart wrong outputs", count_uniform(9), 0);

        // Start re-pulsed at cycle 10 with new operands: both must be ignored
        set_uniform(1, 1);
        shift   = 4'd0;
        relu_en = 1'b0;
        launch();
        cyc = 1;
        while (!done && cyc < BOUND) begin
            if (cyc == 10) begin
                start = 1'b1;
                set_uniform(5, 3);
                shift   = 4'd2;
                relu_en = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clock);
            #1 cyc++;
        end
        check("repulse latency", cyc, LAT);
        check("repulse wrong outputs", count_uniform(9), 0);
        // start held during the done cycle must not launch a run
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        seen = 1'b0;
        repeat (150) begin
            if (done || busy) seen = 1'b1;
            @(posedge clock);
            #1;
        end
        check("start at done ignored", int'(seen), 0);
        check("outputs held after done", count_uniform(9), 0);

        // Reset wins over a simultaneous start
        @(negedge clock);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        start = 1'b0;
        check("reset over start busy", int'(busy), 0);
        @(posedge clock);
        #1 check("reset over start idle", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv2d_lanes.md
CONV2D_LANES -- requirements
Module: conv2d_lanes

Parameters
REQ-001 SIZE, 8, input image side length in pixels.
REQ-002 SIZEKer, 3, kernel side length; SIZEKer <= SIZE.
REQ-003 WIDTH_BIT, 8, signed pixel, kernel and output word width.
REQ-004 LANES, 4, parallel MAC lanes; 1 <= LANES <= OUT, where OUT = SIZE-SIZEKer+1.

Interface
REQ-005 clock  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  request pulse; accepted only in IDLE.
REQ-008 inpMatrixI  in  WIDTH_BIT x [SIZE][SIZE]  signed image.
REQ-009 kernel  in  WIDTH_BIT x [SIZEKer][SIZEKer]  signed kernel.
REQ-010 shift  in  4  arithmetic right-shift applied to each accumulated sum.
REQ-011 relu_en  in  1  enables ReLU clamping of negative results.
REQ-012 busy  out  1  high from start acceptance until done.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 convIxKernelOut  out  WIDTH_BIT x [OUT][OUT]  signed result map.

Function
REQ-015 The FSM SHALL have states IDLE, CAPTURE, MAC, WRITE and FINISH.
- IDLE -> CAPTURE on start.
- CAPTURE -> MAC.
- MAC -> WRITE after SIZEKer*SIZEKer cycles.
- WRITE -> MAC for the next output position, or -> FINISH after the last position.
- FINISH -> IDLE.
REQ-016 CAPTURE SHALL register inpMatrixI, kernel, shift and relu_en, and SHALL clear convIxKernelOut to 0; input changes after CAPTURE SHALL NOT affect the run.
REQ-017 Output rows SHALL be processed in G = ceil(OUT/LANES) row groups.
- Lane p in group g computes output row r = g*LANES + p.
- Lanes with r >= OUT are idle and write nothing.
REQ-018 Within a group, columns c = 0..OUT-1 SHALL be processed in ascending order.
REQ-019 Each MAC phase SHALL accumulate one tap per cycle in row-major kernel order: acc += img[r+k][c+l] * kernel[k][l].
- acc is cleared on MAC entry.
REQ-020 Products SHALL be 2*WIDTH_BIT bits signed; the accumulator SHALL be ACC_W = 2*WIDTH_BIT + clog2(SIZEKer*SIZEKer) bits signed, so it never overflows.
REQ-021 WRITE SHALL compute res = acc >>> shift (arithmetic, floor), then:
- if relu_en and res < 0, res = 0;
- saturate res to [-2^(WIDTH_BIT-1), 2^(WIDTH_BIT-1)-1];
- store res into convIxKernelOut[r][c] for every active lane.
REQ-022 Latency from the start-accepting edge to done SHALL be exactly 2 + G*OUT*(SIZEKer*SIZEKer+1) cycles.
REQ-023 done SHALL assert for exactly one cycle in FINISH; busy SHALL deassert in the same cycle.
REQ-024 convIxKernelOut SHALL hold its values after done until the next CAPTURE.
REQ-025 start asserted while busy SHALL be ignored and not queued.
REQ-026 start and done coincident SHALL NOT start a run; a new start is accepted from IDLE only.

Reset
REQ-027 While reset is high at a clock edge, the block SHALL:
- enter IDLE;
- set busy=0 and done=0;
- clear all accumulators, counters and convIxKernelOut to 0.
REQ-028 reset asserted mid-run SHALL abort the run with no done pulse; the first start after reset deasserts SHALL be accepted normally.
REQ-029 reset SHALL override a simultaneous start.

Structure
REQ-030 A shared package conv_pkg SHALL hold:
- the FSM state enum;
- clog2-based ACC_W and OUT localparam functions;
- the saturate/ReLU function.
REQ-031 Each lane SHALL be one instance of sub-module conv_mac_lane (tap multiply, accumulate, post-process), generated LANES times.
REQ-032 Tap and position counters SHALL be shared across lanes, with a single control FSM in conv2d_lanes.

Verification (SIZE=8, SIZEKer=3, WIDTH_BIT=8, LANES=4, so OUT=6, G=2)
REQ-033 Image all 1, kernel all 1, shift=0, relu_en=0 -> all 36 outputs = 9; done exactly 122 cycles after start; busy high throughout.
REQ-034 Image all 127, kernel all 127, shift=0 -> all outputs 127 (saturated); image all 127, kernel all -127 -> all outputs -128 with relu_en=0 and 0 with relu_en=1.
REQ-035 Image all 1, kernel all 2, shift=1 -> all outputs 9; shift=4 -> all outputs 1 (18>>>4).
REQ-036 Image pixel value = row index, identity-centre kernel (kernel[1][1]=1, others 0) -> convIxKernelOut[r][c] = r+1, including rows 4-5 from group 1 with lanes 2-3 idle.
REQ-037 Reset pulsed at cycle 50 of a run -> no done, outputs 0, FSM in IDLE; restart -> correct result in 122 cycles.
REQ-038 start re-pulsed at cycle 10 of a run -> ignored; single done at cycle 122; inputs changed after CAPTURE -> no effect on the result.
